execute_block: RTL and testbench
================================

Name: execute_block

Overview:
- Execute (EX) stage of the 16-bit MIPS pipeline. Sits between ID and the data-memory stage, which it feeds directly.
- Computes ALU results and memory addresses (ans_ex), and registers store data (DM_data) plus memory control.
- MUL/MULH use a 16-step shift-add unit and stall upstream stages until the product is ready.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported; the multiplier runs WIDTH steps.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- valid_id  in  1  instruction present at op_a/op_b/alu_op
- op_a  in  16  operand A, already forwarded
- op_b  in  16  operand B or immediate, already forwarded
- alu_op  in  4  operation code (encodings in package)
- store_data_id  in  16  rt value for stores
- mem_en_id  in  1  memory access enable
- mem_rw_id  in  1  1 = write, 0 = read
- mem_mux_sel_id  in  1  writeback select (1 = memory data)
- stall  out  1  upstream must hold all id inputs
- valid_ex  out  1  registered instruction valid
- ans_ex  out  16  registered ALU result / memory address
- DM_data  out  16  registered store data
- mem_en_ex  out  1  registered
- mem_rw_ex  out  1  registered
- mem_mux_sel_ex  out  1  registered

Behaviour:
- Reset (sampled on a clk edge with reset=1): all registered outputs go to 0, FSM goes to IDLE, multiplier counter goes to 0. stall is forced to 0 while reset=1. A reset during a multiply aborts it and no result is produced.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOTA, 6 SLL, 7 SRL, 8 SRA: shift amount is op_b[3:0].
  - 9 SLT: signed compare; result is 1 or 0.
  - 10 MUL: low word of unsigned product. 11 MULH: high word.
  - 12 PASSB.
  - 13-15: result 0.
- ADD/SUB wrap modulo 2^16; there is no overflow detection. Loads and stores use ADD for the address.
- Single-cycle ops: inputs are sampled at edge N and outputs are valid after edge N, i.e. 1-cycle latency.
- When valid_id=0, the outputs become a bubble: valid_ex=0, mem_en_ex=0, mem_rw_ex=0, ans_ex=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if valid_id and alu_op is MUL/MULH, stall=1 combinationally. At the next edge, latch op_a, op_b, the op and the control bits into the multiplier, set count=0, go to BUSY, and register a bubble.
  - BUSY: stall=1. Perform one shift-add step per edge; the product is 32 bits. On the edge where count=15 (the 16th step), go to DONE. Register a bubble every cycle.
  - DONE: stall=0. At the next edge, register the MUL/MULH result with the latched control, set valid_ex=1, and go to IDLE. The held mul instruction at the inputs is ignored during this cycle; upstream advances on the same edge.
- MUL latency: 17 stall cycles. The result appears on the 18th edge after the mul is first presented.
- Upstream holds its inputs whenever stall=1, so no instruction is ever dropped.
- A mul with mem_en_id=1 is legal, but the decoder never generates it. Its control bits pass through unchanged.

Decomposition:
- Package exec_pkg:
  - alu_op encodings as localparams
  - FSM state encoding
  - MUL_STEPS = 16
- Sub-module seq_multiplier_16:
  - inputs: start, a, b
  - outputs: busy, done_step, prod[31:0]
  - unsigned shift-add, one step per clk
  - synchronous reset
- The ALU stays combinational inside execute_block.

Test Plan:
- ADD wrap: op_a=0xFFFF, op_b=0x0002 -> ans_ex=0x0001 one edge later, valid_ex=1, stall never asserted.
- SLT signed: op_a=0x8000, op_b=0x0001 -> ans_ex=0x0001. SRA op_a=0x8000, op_b=0x0003 -> ans_ex=0xF000.
- Store: ADD with op_a=0x0010, op_b=0x0004, mem_en=1, mem_rw=1, store_data_id=0xBEEF -> ans_ex=0x0014, DM_data=0xBEEF, mem_en_ex=1, mem_rw_ex=1.
- Multiply: MULH with 0xFFFF × 0xFFFF -> stall high 17 cycles, 17 bubbles, then ans_ex=0xFFFE. MUL with the same operands -> 0x0001. MUL 0x1234 × 0x0056 -> 0x1D78.
- Back-to-back ADD, MUL, ADD -> results in order, no drop and no duplicate of the mul. The second ADD appears one edge after the mul result.
- Reset on the 5th BUSY cycle -> next edge all outputs 0, state IDLE, stall 0 (with valid_id=0). No mul result is ever emitted.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: ALU op codes, FSM states, multiplier step count.
package exec_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOTA  = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULH  = 4'd11;
    localparam logic [3:0] OP_PASSB = 4'd12;

    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/seq_multiplier_16.sv
// Unsigned 16x16 shift-add multiplier, one partial product per clock.
// start loads operands; prod is complete on the edge after done_step.
module seq_multiplier_16
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done_step,
    output logic [31:0] prod
);

    logic        r_busy;
    logic [3:0]  r_count;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_count  <= 4'd0;
            r_acc    <= 32'd0;
            r_mcand  <= 32'd0;
            r_mplier <= 16'd0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_count  <= 4'd0;
            r_acc    <= 32'd0;
            r_mcand  <= {16'd0, a};
            r_mplier <= b;
        end else if (r_busy) begin
            // Multiplicand walks left while multiplier bits are consumed LSB first.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 4'd1;
            if (r_count == 4'(MUL_STEPS - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign done_step = r_busy && (r_count == 4'(MUL_STEPS - 1));
    assign prod      = r_acc;

endmodule

// File: rtl/execute_block.sv
// EX stage: combinational ALU with a registered output stage; MUL/MULH run on a
// sequential multiplier and hold upstream via stall until the product is registered.
module execute_block
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_id,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] store_data_id,
    input  logic             mem_en_id,
    input  logic             mem_rw_id,
    input  logic             mem_mux_sel_id,
    output logic             stall,
    output logic             valid_ex,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] DM_data,
    output logic             mem_en_ex,
    output logic             mem_rw_ex,
    output logic             mem_mux_sel_ex
);

    exec_state_t r_state;
    exec_state_t w_next_state;

    logic             r_valid;
    logic [WIDTH-1:0] r_ans;
    logic [WIDTH-1:0] r_dm;
    logic             r_mem_en;
    logic             r_mem_rw;
    logic             r_mux_sel;

    logic             r_mul_hi;
    logic [WIDTH-1:0] r_mul_dm;
    logic             r_mul_en;
    logic             r_mul_rw;
    logic             r_mul_mux;

    logic             w_is_mul;
    logic             w_stall;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_done_step;
    logic [31:0]      w_prod;
    logic [3:0]       w_shamt;
    logic [WIDTH-1:0] w_alu_res;

    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_ans_nxt;
    logic [WIDTH-1:0] w_dm_nxt;
    logic             w_en_nxt;
    logic             w_rw_nxt;
    logic             w_mux_nxt;

    assign w_is_mul = valid_id && is_mul_op(alu_op);
    assign w_shamt  = op_b[3:0];

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            OP_ADD:   w_alu_res = op_a + op_b;
            OP_SUB:   w_alu_res = op_a - op_b;
            OP_AND:   w_alu_res = op_a & op_b;
            OP_OR:    w_alu_res = op_a | op_b;
            OP_XOR:   w_alu_res = op_a ^ op_b;
            OP_NOTA:  w_alu_res = ~op_a;
            OP_SLL:   w_alu_res = op_a << w_shamt;
            OP_SRL:   w_alu_res = op_a >> w_shamt;
            OP_SRA:   w_alu_res = $signed(op_a) >>> w_shamt;
            OP_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_PASSB: w_alu_res = op_b;
            default:  w_alu_res = '0;
        endcase
    end

    seq_multiplier_16 u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (w_mul_start),
        .a         (op_a),
        .b         (op_b),
        .busy      (w_mul_busy),
        .done_step (w_done_step),
        .prod      (w_prod)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_mul_start  = 1'b0;
        w_valid_nxt  = 1'b0;
        w_ans_nxt    = '0;
        w_dm_nxt     = '0;
        w_en_nxt     = 1'b0;
        w_rw_nxt     = 1'b0;
        w_mux_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mul) begin
                    w_stall      = 1'b1;
                    w_mul_start  = 1'b1;
                    w_next_state = ST_BUSY;
                end else if (valid_id) begin
                    w_valid_nxt = 1'b1;
                    w_ans_nxt   = w_alu_res;
                    w_dm_nxt    = store_data_id;
                    w_en_nxt    = mem_en_id;
                    w_rw_nxt    = mem_rw_id;
                    w_mux_nxt   = mem_mux_sel_id;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (w_done_step || !w_mul_busy) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // The mul still sitting on the inputs is the one being retired here.
                w_next_state = ST_IDLE;
                w_valid_nxt  = 1'b1;
                w_ans_nxt    = r_mul_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
                w_dm_nxt     = r_mul_dm;
                w_en_nxt     = r_mul_en;
                w_rw_nxt     = r_mul_rw;
                w_mux_nxt    = r_mul_mux;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_ans     <= '0;
            r_dm      <= '0;
            r_mem_en  <= 1'b0;
            r_mem_rw  <= 1'b0;
            r_mux_sel <= 1'b0;
            r_mul_hi  <= 1'b0;
            r_mul_dm  <= '0;
            r_mul_en  <= 1'b0;
            r_mul_rw  <= 1'b0;
            r_mul_mux <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_valid   <= w_valid_nxt;
            r_ans     <= w_ans_nxt;
            r_dm      <= w_dm_nxt;
            r_mem_en  <= w_en_nxt;
            r_mem_rw  <= w_rw_nxt;
            r_mux_sel <= w_mux_nxt;
            if (w_mul_start) begin
                r_mul_hi  <= (alu_op == OP_MULH);
                r_mul_dm  <= store_data_id;
                r_mul_en  <= mem_en_id;
                r_mul_rw  <= mem_rw_id;
                r_mul_mux <= mem_mux_sel_id;
            end
        end
    end

    assign stall          = w_stall && !reset;
    assign valid_ex       = r_valid;
    assign ans_ex         = r_ans;
    assign DM_data        = r_dm;
    assign mem_en_ex      = r_mem_en;
    assign mem_rw_ex      = r_mem_rw;
    assign mem_mux_sel_ex = r_mux_sel;

endmodule

// File: tb/tb_execute_block.sv
// Scoreboard bench for execute_block: driver pushes expected results, monitor pops on valid_ex.
module tb_execute_block;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [15:0] op_a, op_b, store_data_id;
    logic [3:0]  alu_op;
    logic        mem_en_id, mem_rw_id, mem_mux_sel_id;
    logic        stall, valid_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
    logic [15:0] ans_ex, DM_data;

    always #5 clk = ~clk;

    execute_block #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .op_a(op_a), .op_b(op_b),
        .alu_op(alu_op), .store_data_id(store_data_id), .mem_en_id(mem_en_id),
        .mem_rw_id(mem_rw_id), .mem_mux_sel_id(mem_mux_sel_id), .stall(stall),
        .valid_ex(valid_ex), .ans_ex(ans_ex), .DM_data(DM_data), .mem_en_ex(mem_en_ex),
        .mem_rw_ex(mem_rw_ex), .mem_mux_sel_ex(mem_mux_sel_ex)
    );

    typedef struct {
        logic [15:0] ans;
        logic [15:0] dm;
        logic        en;
        logic        rw;
        logic        mux;
    } exp_t;

    exp_t exp_q[$];
    int   out_cyc[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural reference: plain arithmetic on the op code's meaning.
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        logic [3:0]  sh;
        p  = {16'd0, a} * {16'd0, b};
        sh = b[3:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~a;
            4'd6:  return a << sh;
            4'd7:  return a >> sh;
            4'd8:  return 16'($signed(a) >>> sh);
            4'd9:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd10: return p[15:0];
            4'd11: return p[31:16];
            4'd12: return b;
            default: return 16'd0;
        endcase
    endfunction

    // Monitor: pop and compare on every valid output, bubble-check otherwise.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (valid_ex === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual ans=%0h required no output (cycle %0d)",
                                 ans_ex, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        out_cyc.push_back(cyc);
                        chk("ans_ex", {16'd0, ans_ex}, {16'd0, e.ans});
                        chk("DM_data", {16'd0, DM_data}, {16'd0, e.dm});
                        chk("mem_en_ex", {31'd0, mem_en_ex}, {31'd0, e.en});
                        chk("mem_rw_ex", {31'd0, mem_rw_ex}, {31'd0, e.rw});
                        chk("mem_mux_sel_ex", {31'd0, mem_mux_sel_ex}, {31'd0, e.mux});
                    end
                end else begin
                    chk("bubble_valid", {31'd0, valid_ex}, 32'd0);
                    chk("bubble_ans", {16'd0, ans_ex}, 32'd0);
                    chk("bubble_mem_en", {31'd0, mem_en_ex}, 32'd0);
                    chk("bubble_mem_rw", {31'd0, mem_rw_ex}, 32'd0);
                end
            end
        end
    end

    // Driver: called at a negedge; holds inputs while stall is high, then lets one edge consume them.
    task automatic send(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] sd, input logic en,
                        input logic rw, input logic mux, output int scyc);
        exp_t e;
        valid_id = v; alu_op = op; op_a = a; op_b = b; store_data_id = sd;
        mem_en_id = en; mem_rw_id = rw; mem_mux_sel_id = mux;
        #1;
        scyc = 0;
        while (stall === 1'b1 && scyc < 100) begin
            @(negedge clk);
            #1;
            scyc++;
        end
        if (scyc >= 100) chk("stall_timeout", scyc, 32'd0);
        if (v) begin
            e.ans = model(op, a, b);
            e.dm  = sd;
            e.en  = en;
            e.rw  = rw;
            e.mux = mux;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        int sc;
        for (int i = 0; i < n; i++) send(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, sc);
    endtask

    initial begin
        int          sc;
        int          n;
        logic        v, en, rw, mux;
        logic [3:0]  op;
        logic [15:0] a, b, sd;

        reset = 1'b1; valid_id = 1'b0; alu_op = 4'd0; op_a = 16'd0; op_b = 16'd0;
        store_data_id = 16'd0; mem_en_id = 1'b0; mem_rw_id = 1'b0; mem_mux_sel_id = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid_ex}, 32'd0);
        chk("rst_ans", {16'd0, ans_ex}, 32'd0);
        chk("rst_dm", {16'd0, DM_data}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en_ex}, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw_ex}, 32'd0);
        chk("rst_mux", {31'd0, mem_mux_sel_ex}, 32'd0);
        valid_id = 1'b1; alu_op = OP_MUL;
        #1 chk("rst_stall_forced_low", {31'd0, stall}, 32'd0);
        valid_id = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mon_on = 1'b1;

        send(1'b1, OP_ADD, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        chk("add_wrap_no_stall", sc, 32'd0);
        send(1'b1, OP_SLT, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        send(1'b1, OP_SRA, 16'h8000, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        send(1'b1, OP_ADD, 16'h0010, 16'h0004, 16'hBEEF, 1'b1, 1'b1, 1'b0, sc);
        send(1'b1, OP_MULH, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        chk("mulh_stall_cycles", sc, 32'd17);
        send(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        chk("mul_stall_cycles", sc, 32'd17);
        send(1'b1, OP_MUL, 16'h1234, 16'h0056, 16'h0000, 1'b0, 1'b0, 1'b1, sc);
        idle(2);

        send(1'b1, OP_ADD, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        send(1'b1, OP_MUL, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        send(1'b1, OP_ADD, 16'h0007, 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0, sc);
        idle(3);
        n = out_cyc.size();
        chk("b2b_count_ge3", (n >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (n >= 3) begin
            chk("b2b_mul_result_edge", out_cyc[n-2] - out_cyc[n-3], 32'd18);
            chk("b2b_add_after_mul_edge", out_cyc[n-1] - out_cyc[n-2], 32'd1);
        end

        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 99) < 85);
            op  = 4'($urandom_range(0, 15));
            a   = 16'($urandom);
            b   = 16'($urandom);
            sd  = 16'($urandom);
            en  = 1'($urandom);
            rw  = 1'($urandom);
            mux = 1'($urandom);
            send(v, op, a, b, sd, en, rw, mux, sc);
            chk("rand_stall_cycles", sc, (v && (op == OP_MUL || op == OP_MULH)) ? 32'd17 : 32'd0);
        end
        idle(2);

        // Abort a multiply with reset in its 5th BUSY cycle.
        valid_id = 1'b1; alu_op = OP_MUL; op_a = 16'hFFFF; op_b = 16'hFFFF;
        mem_en_id = 1'b0; mem_rw_id = 1'b0; mem_mux_sel_id = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1; valid_id = 1'b0;
        #1 chk("abort_stall_in_reset", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_valid", {31'd0, valid_ex}, 32'd0);
        chk("abort_ans", {16'd0, ans_ex}, 32'd0);
        chk("abort_mem_en", {31'd0, mem_en_ex}, 32'd0);
        chk("abort_mem_rw", {31'd0, mem_rw_ex}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(30);
        send(1'b1, OP_SUB, 16'h0000, 16'h0001, 16'h1111, 1'b0, 1'b0, 1'b1, sc);
        chk("post_abort_no_stall", sc, 32'd0);
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
